// File: rtl/multi_debouncer.sv
// N-channel push-button debouncer with long-press detection and auto-repeat.
// Each channel is synchronised, debounced, and then timed independently.
module multi_debouncer #(
   parameter int N_CH       = 4,
   parameter int CNT_W      = 16,
   parameter int ACTIVE_LOW = 1,
   parameter int LONG_CYC   = 5000000,
   parameter int REPEAT_CYC = 1000000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] button,
   input  logic            repeat_en,
   output logic [N_CH-1:0] button_pressed,
   output logic [N_CH-1:0] button_down,
   output logic [N_CH-1:0] button_up,
   output logic [N_CH-1:0] button_long,
   output logic [N_CH-1:0] button_repeat
);

   localparam int HOLD_W = $clog2(LONG_CYC + 1);
   localparam int REP_W  = $clog2(REPEAT_CYC + 1);

   localparam logic [N_CH-1:0]   POL_MASK = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC);
   localparam logic [REP_W-1:0]  REP_LAST = REP_W'(REPEAT_CYC - 1);

   logic [N_CH-1:0]   r_s0;
   logic [N_CH-1:0]   r_s1;
   logic [N_CH-1:0]   r_state;
   logic [N_CH-1:0]   r_fired;
   logic [CNT_W-1:0]  r_cnt  [N_CH];
   logic [HOLD_W-1:0] r_hold [N_CH];
   logic [REP_W-1:0]  r_rep  [N_CH];

   logic [N_CH-1:0]   w_idle;
   logic [N_CH-1:0]   w_flip;
   logic [N_CH-1:0]   w_long_due;
   logic [N_CH-1:0]   w_rep_due;

   // r_fired marks that this press already produced its long pulse; repeats are phased from it.
   always_comb begin
      w_idle     = ~(r_state ^ r_s1);
      w_flip     = '0;
      w_long_due = '0;
      w_rep_due  = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         w_flip[ch]     = ~w_idle[ch] & (&r_cnt[ch]);
         w_long_due[ch] = r_state[ch] & ~r_fired[ch] & (r_hold[ch] == HOLD_MAX);
         w_rep_due[ch]  = r_state[ch] & r_fired[ch] & (r_rep[ch] == REP_LAST);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s0           <= '0;
         r_s1           <= '0;
         r_state        <= '0;
         r_fired        <= '0;
         button_pressed <= '0;
         button_down    <= '0;
         button_up      <= '0;
         button_long    <= '0;
         button_repeat  <= '0;
      end else begin
         r_s0           <= button ^ POL_MASK;
         r_s1           <= r_s0;
         r_state        <= r_state ^ w_flip;
         r_fired        <= r_state & (r_fired | w_long_due);
         button_pressed <= r_state;
         button_down    <= r_state & ~button_pressed;
         button_up      <= ~r_state & button_pressed;
         button_long    <= w_long_due;
         button_repeat  <= w_rep_due & {N_CH{repeat_en}};
      end
   end

   // Hold and repeat counters only run while the debounced state is held; release clears them.
   always_ff @(posedge clk) begin
      for (int ch = 0; ch < N_CH; ch++) begin
         if (reset) begin
            r_cnt[ch]  <= '0;
            r_hold[ch] <= '0;
            r_rep[ch]  <= '0;
         end else begin
            if (w_idle[ch]) begin
               r_cnt[ch] <= '0;
            end else begin
               r_cnt[ch] <= r_cnt[ch] + CNT_W'(1);
            end

            if (!r_state[ch]) begin
               r_hold[ch] <= '0;
            end else if (r_hold[ch] != HOLD_MAX) begin
               r_hold[ch] <= r_hold[ch] + HOLD_W'(1);
            end else begin
               r_hold[ch] <= r_hold[ch];
            end

            if (!(r_state[ch] && r_fired[ch])) begin
               r_rep[ch] <= '0;
            end else if (r_rep[ch] == REP_LAST) begin
               r_rep[ch] <= '0;
            end else begin
               r_rep[ch] <= r_rep[ch] + REP_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_multi_debouncer.sv
// Bench for multi_debouncer: directed test-plan steps then random bouncing,
// checked every cycle against a timeline model of presses, holds and repeats.
module tb_multi_debouncer;

   localparam int N_CH       = 2;
   localparam int CNT_W      = 3;
   localparam int ACTIVE_LOW = 1;
   localparam int LONG       = 20;
   localparam int REP        = 5;
   localparam int DEB        = 8;
   localparam int MAXC       = 4096;

   logic       clk;
   logic       reset;
   logic       repeat_en;
   logic [1:0] button;
   logic [1:0] button_pressed;
   logic [1:0] button_down;
   logic [1:0] button_up;
   logic [1:0] button_long;
   logic [1:0] button_repeat;

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;

   // exp_p[t] = expected debounced level seen after edge t
   logic [1:0] exp_p [0:MAXC-1];
   int         run_c   [2];
   logic       acc_c   [2];
   int         start_c [2];
   logic       valid_c [2];

   int last_down0, last_up0, last_long0, last_rep0;
   int long_cnt0, rep_cnt0, ev1_cnt;
   int saw_dn11, saw_up11;

   multi_debouncer #(
      .N_CH(N_CH), .CNT_W(CNT_W), .ACTIVE_LOW(ACTIVE_LOW),
      .LONG_CYC(LONG), .REPEAT_CYC(REP)
   ) dut (
      .clk(clk), .reset(reset), .button(button), .repeat_en(repeat_en),
      .button_pressed(button_pressed), .button_down(button_down),
      .button_up(button_up), .button_long(button_long),
      .button_repeat(button_repeat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_bits(input string tag, input logic [1:0] got, input logic [1:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
      end
   endtask

   task automatic check_int(input string tag, input int got, input int exp);
      compared++;
      assert (got == exp) else begin
         mismatched++;
         $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   task automatic step(input logic [1:0] b, input logic r, input logic e);
      logic [1:0] ep, ed, eu, el, er;
      logic       nr, pr, prev;
      int         age;
      button    = b;
      reset     = r;
      repeat_en = e;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc + 4 >= MAXC) begin
         $display("FAIL model_capacity cyc=%0d got=%0d exp<%0d", cyc, cyc + 4, MAXC);
         $fatal(1, "model capacity exceeded");
      end
      for (int ch = 0; ch < 2; ch++) begin
         if (r) begin
            run_c[ch]   = 0;
            acc_c[ch]   = 1'b0;
            valid_c[ch] = 1'b0;
            for (int d = 0; d < 4; d++) exp_p[cyc + d][ch] = 1'b0;
         end else begin
            nr = (ACTIVE_LOW != 0) ? ~b[ch] : b[ch];
            if (nr != acc_c[ch]) begin
               run_c[ch]++;
               if (run_c[ch] == DEB) begin
                  acc_c[ch] = nr;
                  run_c[ch] = 0;
               end
            end else begin
               run_c[ch] = 0;
            end
            // accepted on this sample -> visible three edges later
            exp_p[cyc + 3][ch] = acc_c[ch];
         end
         pr     = exp_p[cyc][ch];
         prev   = exp_p[cyc - 1][ch];
         ep[ch] = pr;
         ed[ch] = !r && pr && !prev;
         eu[ch] = !r && !pr && prev;
         if (ed[ch]) begin
            start_c[ch] = cyc;
            valid_c[ch] = 1'b1;
         end
         if (!pr) valid_c[ch] = 1'b0;
         age    = cyc - start_c[ch];
         el[ch] = valid_c[ch] && pr && (age == LONG);
         er[ch] = valid_c[ch] && pr && e && (age > LONG) && (((age - LONG) % REP) == 0);
      end
      check_bits("pressed", button_pressed, ep);
      check_bits("down",    button_down,    ed);
      check_bits("up",      button_up,      eu);
      check_bits("long",    button_long,    el);
      check_bits("repeat",  button_repeat,  er);
      if (button_down[0])   last_down0 = cyc;
      if (button_up[0])     last_up0   = cyc;
      if (button_long[0])   begin last_long0 = cyc; long_cnt0++; end
      if (button_repeat[0]) begin last_rep0  = cyc; rep_cnt0++;  end
      if (button_down[1] | button_up[1] | button_long[1] | button_repeat[1] | button_pressed[1]) ev1_cnt++;
      if (button_down == 2'b11) saw_dn11 = 1;
      if (button_up == 2'b11)   saw_up11 = 1;
   endtask

   initial begin
      int k, d, kr, rc, snap_ev1, snap_rep, snap_long;
      logic [1:0] rb;
      logic       ren;
      int         seg [2];

      for (int i = 0; i < MAXC; i++) exp_p[i] = 2'b00;
      for (int ch = 0; ch < 2; ch++) begin
         run_c[ch] = 0; acc_c[ch] = 1'b0; start_c[ch] = 0; valid_c[ch] = 1'b0; seg[ch] = 0;
      end
      last_down0 = 0; last_up0 = 0; last_long0 = 0; last_rep0 = 0;
      long_cnt0 = 0; rep_cnt0 = 0; ev1_cnt = 0; saw_dn11 = 0; saw_up11 = 0;
      button = 2'b11; reset = 1'b1; repeat_en = 1'b1;

      repeat (3) step(2'b11, 1'b1, 1'b1);
      repeat (5) step(2'b11, 1'b0, 1'b1);

      // clean press, long press and repeats, with repeat_en dropped around +30
      k = cyc + 1; d = k + 10; snap_ev1 = ev1_cnt; snap_rep = rep_cnt0;
      for (int i = 0; i < 50; i++)
         step(2'b10, 1'b0, ((cyc + 1 >= d + 28) && (cyc + 1 <= d + 32)) ? 1'b0 : 1'b1);
      check_int("down_latency", last_down0 - k, 10);
      check_int("long_latency", last_long0 - last_down0, LONG);
      check_int("repeat_count", rep_cnt0 - snap_rep, 2);
      check_int("last_repeat",  last_rep0 - d, 35);
      check_int("ch1_quiet",    ev1_cnt - snap_ev1, 0);
      kr = cyc + 1;
      repeat (15) step(2'b11, 1'b0, 1'b1);
      check_int("up_latency", last_up0 - kr, 10);

      // bounce: 6 low, 2 high, then steady low
      repeat (6) step(2'b10, 1'b0, 1'b1);
      repeat (2) step(2'b11, 1'b0, 1'b1);
      k = cyc + 1;
      repeat (15) step(2'b10, 1'b0, 1'b1);
      check_int("bounce_down", last_down0 - k, 10);
      repeat (15) step(2'b11, 1'b0, 1'b1);

      // short hold: no long pulse
      snap_long = long_cnt0;
      repeat (12) step(2'b10, 1'b0, 1'b1);
      kr = cyc + 1;
      repeat (15) step(2'b11, 1'b0, 1'b1);
      check_int("short_up",   last_up0 - kr, 10);
      check_int("short_long", long_cnt0 - snap_long, 0);

      // simultaneous press and release
      repeat (15) step(2'b00, 1'b0, 1'b1);
      repeat (15) step(2'b11, 1'b0, 1'b1);
      check_int("sim_down", saw_dn11, 1);
      check_int("sim_up",   saw_up11, 1);

      // reset mid-hold with the button still down
      k = cyc + 1; d = k + 10;
      while (cyc + 1 < d + 15) step(2'b10, 1'b0, 1'b1);
      step(2'b10, 1'b1, 1'b1);
      rc = cyc;
      repeat (45) step(2'b10, 1'b0, 1'b1);
      check_int("rst_redown", last_down0 - (rc + 1), 10);
      check_int("rst_long",   last_long0 - last_down0, LONG);
      repeat (15) step(2'b11, 1'b0, 1'b1);

      // random bouncing segments, repeat_en toggling, rare resets
      rb = 2'b11; ren = 1'b1;
      for (int i = 0; i < 1800; i++) begin
         for (int ch = 0; ch < 2; ch++) begin
            if (seg[ch] == 0) begin
               rb[ch]  = 1'($urandom_range(0, 1));
               seg[ch] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 70) : $urandom_range(1, 12);
            end
            seg[ch]--;
         end
         if ($urandom_range(0, 9) == 0) ren = ~ren;
         step(rb, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0, ren);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/multi_debouncer.md
Name: multi_debouncer

Overview:
- N-channel push-button debouncer with long-press detection and auto-repeat.
- Generalises the single-button debouncer: per-channel two-flop synchronisers, configurable input polarity, and configurable debounce period.
- Adds hold timing: a long-press pulse, then periodic repeat pulses while the button is held.
- Sits between the front-panel buttons and the control/menu logic. All outputs are in the clk domain.

Parameters:
- N_CH, 4, number of independent button channels.
- CNT_W, 16, debounce counter width; the input must disagree with the stable state for 2^CNT_W consecutive cycles to be accepted.
- ACTIVE_LOW, 1, 1 = raw input low means pressed; 0 = raw input high means pressed.
- LONG_CYC, 5000000, cycles from button_down to the button_long pulse (>=1).
- REPEAT_CYC, 1000000, cycles between repeat pulses after button_long (>=1).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- button  in  N_CH  raw asynchronous button inputs, polarity per ACTIVE_LOW.
- repeat_en  in  1  enables button_repeat pulses (all channels).
- button_pressed  out  N_CH  debounced level, 1 = held down.
- button_down  out  N_CH  1-cycle pulse on accepted press.
- button_up  out  N_CH  1-cycle pulse on accepted release.
- button_long  out  N_CH  1-cycle pulse after LONG_CYC cycles held.
- button_repeat  out  N_CH  1-cycle pulse every REPEAT_CYC cycles after button_long, while held and repeat_en=1.

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, on port reset. All outputs are registered.
- Reset values:
  - All outputs 0.
  - Sync flops, debounce state, and all counters 0 (sync flops hold the "not pressed" value).
- Synchroniser: s0 <= button XOR ACTIVE_LOW; s1 <= s0. This gives a normalised active-high level.
- Debounce, per channel:
  - idle = (state == s1).
  - If idle: cnt <= 0.
  - Else: cnt <= cnt+1 (wraps to 0). When cnt is all-ones and not idle, state <= ~state.
  - Any return to agreement before cnt saturates clears cnt. Glitches shorter than 2^CNT_W cycles are therefore rejected.
  - button_pressed = state.
- Latency: a raw edge sampled at edge k first shows on button_pressed after edge k+2^CNT_W+2, provided the input stays stable.
- Edge pulses: button_down / button_up are registered. Each is high in exactly the first cycle that button_pressed shows 1 / 0. Never high for two consecutive cycles.
- Hold timer, per channel:
  - hold counter, width $clog2(LONG_CYC+1). Zeroed while state=0. Counts up while state=1, saturating at LONG_CYC.
  - button_long is high exactly LONG_CYC cycles after the button_down cycle, once per press.
  - Release before then: no button_long.
- Repeat, per channel:
  - rep counter, width $clog2(REPEAT_CYC+1). Runs only after button_long has fired and state=1.
  - Reloads to 0 on each pulse and runs regardless of repeat_en.
  - button_repeat pulses at LONG_CYC+n*REPEAT_CYC cycles after button_down (n>=1), gated by repeat_en in the pulse cycle.
  - Toggling repeat_en does not shift the phase.
- Release: on the button_up cycle the hold and rep counters clear. No long/repeat pulse may coincide with button_up. A long/repeat pulse due in that cycle is suppressed.
- Channels are fully independent. Simultaneous events on different channels all appear in the same cycle.
- Reset mid-operation clears everything in the next cycle with no pulses. A button held through reset is re-debounced after reset falls and produces a normal button_down.

Test Plan:
Config: N_CH=2, CNT_W=3, ACTIVE_LOW=1, LONG_CYC=20, REPEAT_CYC=5.
- Clean press: button[0] driven 0 and sampled at edge k -> button_pressed[0] rises and button_down[0] pulses once after edge k+10. Channel 1 outputs stay 0.
- Bounce: button[0] low 6 cycles, high 2, low steady -> no output during the bounce. button_down[0] appears 10 cycles after the final falling edge.
- Long/repeat: hold with repeat_en=1 -> button_long[0] 20 cycles after button_down[0], button_repeat[0] at +25, +30, +35. Set repeat_en=0 over +30 -> that pulse is absent, +35 still occurs.
- Short hold: release after 12 cycles pressed -> button_up[0] pulses 10 cycles after the release sample. No button_long[0].
- Simultaneous: both channels pressed in the same cycle -> button_down = 2'b11 in one cycle. Both release -> button_up = 2'b11.
- Reset mid-hold: assert reset 1 cycle at hold=15 with the button still low -> all outputs 0 next cycle. button_down[0] reappears 10 cycles after s1 re-syncs; long fires 20 cycles after that.
